delay_line_ctrl: RTL and testbench

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

---
 rtl/dlc_pkg.sv | 14 +
 rtl/dlc_stage_array.sv | 58 +++++
 rtl/delay_line_ctrl.sv | 136 +++++++++++++
 tb/tb_delay_line_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlc_pkg.sv
// Shared constants and FSM state encoding for the delay-line controller.
package dlc_pkg;

  localparam int unsigned DLC_WIDTH = 16;
  localparam int unsigned DLC_DEPTH = 8;

  typedef logic [1:0] dlc_state_t;

  localparam dlc_state_t ST_IDLE  = 2'd0;
  localparam dlc_state_t ST_FILL  = 2'd1;
  localparam dlc_state_t ST_RUN   = 2'd2;
  localparam dlc_state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/dlc_stage_array.sv
// Enabled data+valid shift array; stage 0 takes the new sample, the last stage falls out.
// DLC_TAP_OUT_EN exposes every stage's data and valid bit.
module dlc_stage_array
  import dlc_pkg::*;
#(
  parameter int unsigned WIDTH = DLC_WIDTH,
  parameter int unsigned DEPTH = DLC_DEPTH
) (
  input  logic             ck,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] shift_data,
  input  logic             shift_valid,
  output logic [WIDTH-1:0] last_data,
  output logic             last_valid,
  output logic             any_valid
`ifdef DLC_TAP_OUT_EN
  ,
  output logic [WIDTH*DEPTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid
`endif
);

  localparam int unsigned DW = WIDTH * DEPTH;

  logic [DW-1:0]    data_q,  data_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  // Stage k lives at bits [k*WIDTH +: WIDTH]; a shift moves every stage up by one.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (shift_en) begin
      data_d  = {data_q[DW-WIDTH-1:0], shift_data};
      valid_d = {valid_q[DEPTH-2:0], shift_valid};
    end
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign last_data  = data_q[DW-WIDTH +: WIDTH];
  assign last_valid = valid_q[DEPTH-1];
  assign any_valid  = |valid_q;

`ifdef DLC_TAP_OUT_EN
  assign stage_data  = data_q;
  assign stage_valid = valid_q;
`endif

endmodule

// File: rtl/delay_line_ctrl.sv
// DEPTH-stage sample delay line with ready/valid handshakes and a drain (flush) mode.
// Optional DLC_TAP_OUT_EN adds taps/tap_valid ports mirroring every stage.
module delay_line_ctrl
  import dlc_pkg::*;
#(
  parameter int unsigned WIDTH = DLC_WIDTH,
  parameter int unsigned DEPTH = DLC_DEPTH
) (
  input  logic             ck,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  input  logic             out_ready,
  output logic [1:0]       state
`ifdef DLC_TAP_OUT_EN
  ,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_valid
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  dlc_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             slot_free;
  logic             flushing;
  logic             accept;
  logic             shift_en;
  logic             shift_valid;
  logic [WIDTH-1:0] shift_data;
  logic             load;
  logic [WIDTH-1:0] last_data;
  logic             last_valid;
  logic             any_valid;

  // Handshake and shift control; a flush drains zeros whenever the output slot is free.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    flushing  = (state_q == ST_FLUSH);
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: in_ready = 1'b1;
      ST_RUN:           in_ready = slot_free;
      default:          in_ready = 1'b0;
    endcase
    accept      = in_valid && in_ready;
    shift_en    = flushing ? slot_free : accept;
    shift_valid = !flushing;
    shift_data  = flushing ? '0 : din;
    load        = shift_en && last_valid;
  end

  dlc_stage_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stages (
    .ck          (ck),
    .reset_n     (reset_n),
    .shift_en    (shift_en),
    .shift_data  (shift_data),
    .shift_valid (shift_valid),
    .last_data   (last_data),
    .last_valid  (last_valid),
    .any_valid   (any_valid)
`ifdef DLC_TAP_OUT_EN
    ,
    .stage_data  (taps),
    .stage_valid (tap_valid)
`endif
  );

  // Next state, fill count and output register.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;

    if (shift_en) begin
      count_d = count_q + CW'(shift_valid) - CW'(load);
    end

    if (load) begin
      out_valid_d = 1'b1;
      dout_d      = last_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (count_d == CW'(DEPTH)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) state_d = ST_FLUSH;
      end
      default: begin
        if (!any_valid && !out_valid_q) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign state     = state_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl: queue-based reference model compared every
// cycle, an in-order scoreboard, and directed literal checks.
module tb_delay_line_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic         ck = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] din;
  logic         in_ready;
  logic         flush;
  logic         out_valid;
  logic [W-1:0] dout;
  logic         out_ready;
  logic [1:0]   state;
`ifdef DLC_TAP_OUT_EN
  logic [W*D-1:0] taps;
  logic [D-1:0]   tap_valid;
`endif

  always #5 ck = ~ck;

  delay_line_ctrl #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .ck        (ck),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .din       (din),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .dout      (dout),
    .out_ready (out_ready),
    .state     (state)
`ifdef DLC_TAP_OUT_EN
    ,
    .taps      (taps),
    .tap_valid (tap_valid)
`endif
  );

  // Reference model: the line is a queue of DEPTH slots, newest at the front.
  typedef struct {
    logic         v;
    logic [W-1:0] d;
  } slot_t;

  slot_t        line[$];
  logic         m_ov;
  logic [W-1:0] m_dout;
  logic [1:0]   m_st;

  logic [W-1:0] sb[$];
  logic [W-1:0] emitted[$];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic exp_ready();
    case (m_st)
      2'd0, 2'd1: return 1'b1;
      2'd2:       return !m_ov || out_ready;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int line_count();
    int n = 0;
    foreach (line[i]) if (line[i].v) n++;
    return n;
  endfunction

  always @(posedge ck or negedge reset_n) begin : model
    slot_t popped;
    slot_t fresh;
    logic  acc;
    logic  shf;
    int    cnt_old;
    logic  ov_old;
    if (!reset_n) begin
      line.delete();
      for (int i = 0; i < int'(D); i++) line.push_back('{v: 1'b0, d: '0});
      m_ov   = 1'b0;
      m_dout = '0;
      m_st   = 2'd0;
    end else begin
      acc     = in_valid && exp_ready();
      shf     = (m_st == 2'd3) ? (!m_ov || out_ready) : acc;
      cnt_old = line_count();
      ov_old  = m_ov;
      popped  = '{v: 1'b0, d: '0};
      if (shf) begin
        popped  = line.pop_back();
        fresh.v = (m_st != 2'd3);
        fresh.d = (m_st == 2'd3) ? '0 : din;
        line.push_front(fresh);
      end
      if (popped.v) begin
        m_ov   = 1'b1;
        m_dout = popped.d;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      case (m_st)
        2'd0: if (acc) m_st = 2'd1;
        2'd1: begin
          if (flush) m_st = 2'd3;
          else if (line_count() == int'(D)) m_st = 2'd2;
        end
        2'd2: if (flush) m_st = 2'd3;
        default: if (cnt_old == 0 && !ov_old) m_st = 2'd0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus the in-order scoreboard.
  task automatic compare_cycle();
    logic [W-1:0] head;
    chk("in_ready",  32'(in_ready),  32'(exp_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("dout",      32'(dout),      32'(m_dout));
    chk("state",     32'(state),     32'(m_st));
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got dout %0h, required no output", dout);
        end else begin
          head = sb.pop_front();
          chk("sb_order", 32'(dout), 32'(head));
        end
      end
      if (in_valid && exp_ready()) sb.push_back(din);
    end
  endtask

  task automatic tick();
    @(negedge ck);
    compare_cycle();
    @(posedge ck);
    #1;
  endtask

  // Runs until IDLE; out_ready follows pattern pd when use_pat, else stays 1 and outputs are recorded.
  task automatic drain(input int maxc, input logic use_pat, input logic [15:0] pd);
    logic done = 1'b0;
    emitted.delete();
    for (int c = 0; c < maxc && !done; c++) begin
      if (use_pat) out_ready = pd[c % 16];
      tick();
      if (!use_pat && out_valid) emitted.push_back(dout);
      if (state == 2'd0) done = 1'b1;
    end
    out_ready = 1'b1;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: state %0d, required 0", state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] pv;
    logic [23:0] po;
    pv = 24'b1101_1011_0111_1110_1001_1111;
    po = 24'b1010_0111_1100_1011_0110_0101;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ov",    32'(out_valid), 32'd0);
    chk("rst_dout",  32'(dout), 32'd0);
    reset_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Fill with 1..8: no output, RUN after the 8th accept.
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din = 16'(i);
      tick();
      chk("fill_ov", 32'(out_valid), 32'd0);
      chk("fill_state", 32'(state), (i < 8) ? 32'd1 : 32'd2);
    end

    // 9..12 push out 1..4.
    for (int i = 9; i <= 12; i++) begin
      din = 16'(i);
      tick();
      chk("run_ov", 32'(out_valid), 32'd1);
      chk("run_dout", 32'(dout), 32'(i - 8));
    end

    // Back-pressure: frozen output, no accepts.
    out_ready = 1'b0;
    din = 16'd13;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_dout", 32'(dout), 32'd4);
      chk("bp_ov", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_resume1", 32'(dout), 32'd5);
    din = 16'd14;
    tick();
    chk("bp_resume2", 32'(dout), 32'd6);

    // Mixed traffic.
    for (int i = 0; i < 24; i++) begin
      in_valid  = pv[i];
      out_ready = po[i];
      din       = 16'(16'h100 + i);
      tick();
    end

    // Flush from RUN under back-pressure.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_run_state", 32'(state), 32'd3);
    drain(120, 1'b1, 16'b0110_1101_0011_1010);
    chk("sb_empty_run", 32'(sb.size()), 32'd0);

    // Flush in IDLE is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", 32'(state), 32'd0);

    // Accept 1..5 then flush.
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_fill_state", 32'(state), 32'd3);
    drain(40, 1'b0, 16'h0000);
    chk("flush5_count", 32'(emitted.size()), 32'd5);
    for (int i = 0; i < emitted.size() && i < 5; i++) chk("flush5_val", 32'(emitted[i]), 32'(i + 1));
    chk("flush5_idle", 32'(state), 32'd0);

    // Flush together with an accept: the accepted sample is drained too.
    in_valid = 1'b1;
    din = 16'h31;
    tick();
    din = 16'h32;
    tick();
    din = 16'h33;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_acc_state", 32'(state), 32'd3);
    drain(40, 1'b0, 16'h0000);
    chk("flush_acc_count", 32'(emitted.size()), 32'd3);
    for (int i = 0; i < emitted.size() && i < 3; i++) chk("flush_acc_val", 32'(emitted[i]), 32'(16'h31 + i));
    chk("sb_empty_fill", 32'(sb.size()), 32'd0);

    // Reset mid-RUN discards held samples.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 16'(16'h40 + i);
      tick();
    end
    chk("pre_rst_dout", 32'(dout), 32'h41);
    chk("pre_rst_state", 32'(state), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 16'(16'h50 + i);
      tick();
      chk("post_rst_ov", 32'(out_valid), 32'd0);
    end
    chk("post_rst_state", 32'(state), 32'd2);
    din = 16'h58;
    tick();
    chk("post_rst_first", 32'(dout), 32'h50);

    // Fresh fill with A0..A7.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 16'(16'hA0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("a_fill_state", 32'(state), 32'd2);
`ifdef DLC_TAP_OUT_EN
    chk("tap_stage0", 32'(taps[0 +: W]), 32'hA7);
    chk("tap_stage7", 32'(taps[7*W +: W]), 32'hA0);
    chk("tap_valid", 32'(tap_valid), 32'hFF);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
